pc_sequencer: RTL and testbench

- Fetch/branch sequencer for the 8-bit core.
- Owns the program counter and the CVZN flag register, and fetches instruction bytes over a req/ack memory handshake.
- Hands non-branch opcodes to the execute stage.
- Resolves branch opcodes (high nibble 0xE) by driving cccc/cvzn into the downstream branch_logic block and consuming its combinational go result.

---
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 tb/tb_pc_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/branch sequencer owning the PC and CVZN flags
//
// Fetches opcode bytes over a req/ack memory port, issues non-branch opcodes
// to the execute stage, and resolves two-byte branches (opcode, absolute
// target) using an external combinational branch_logic block.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   mem_req/mem_addr  fetch request and address (= PC)
//   mem_ack/mem_rdata memory accept and fetched byte (valid with mem_ack)
//   flags_we/flags_in flag register load from the ALU ({C,V,Z,N})
//   cvzn, cccc        registered flags and condition code to branch_logic
//   go                branch decision back from branch_logic
//   instr_valid/instr_op/instr_ready  execute-stage handshake
//   branch_taken      one-cycle pulse when a branch redirects the PC

module pc_sequencer #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [3:0] BR_NIBBLE = 4'hE
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_rdata,
  input  logic       flags_we,
  input  logic [3:0] flags_in,
  output logic [3:0] cvzn,
  output logic [3:0] cccc,
  input  logic       go,
  output logic       instr_valid,
  output logic [7:0] instr_op,
  input  logic       instr_ready,
  output logic       branch_taken
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH_OP,
    S_FETCH_TGT,
    S_RESOLVE,
    S_ISSUE
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] pc;
  logic [7:0] pc_next;
  logic [7:0] opcode;
  logic [7:0] target;
  logic       op_load;
  logic       tgt_load;
  logic       cccc_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_RESET;
      pc     <= RESET_PC;
      opcode <= 8'h00;
      target <= 8'h00;
      cvzn   <= 4'h0;
      cccc   <= 4'h0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (op_load) begin
        opcode <= mem_rdata;
      end
      if (tgt_load) begin
        target <= mem_rdata;
      end
      // cccc is loaded on entry to RESOLVE so it is valid for that whole
      // cycle and then simply holds until the next branch.
      if (cccc_load) begin
        cccc <= opcode[3:0];
      end
      if (flags_we) begin
        cvzn <= flags_in;
      end
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = pc;
    op_load      = 1'b0;
    tgt_load     = 1'b0;
    cccc_load    = 1'b0;
    mem_req      = 1'b0;
    instr_valid  = 1'b0;
    branch_taken = 1'b0;
    case (state)
      S_RESET: begin
        state_next = S_FETCH_OP;
      end
      S_FETCH_OP: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          op_load = 1'b1;
          pc_next = pc + 8'd1;
          if (mem_rdata[7:4] == BR_NIBBLE) begin
            state_next = S_FETCH_TGT;
          end else begin
            state_next = S_ISSUE;
          end
        end
      end
      S_FETCH_TGT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          tgt_load   = 1'b1;
          cccc_load  = 1'b1;
          pc_next    = pc + 8'd1;
          state_next = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        // Not taken leaves PC pointing past the target byte.
        if (go) begin
          pc_next      = target;
          branch_taken = 1'b1;
        end
        state_next = S_FETCH_OP;
      end
      S_ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_next = S_FETCH_OP;
        end
      end
      default: begin
        state_next = S_RESET;
      end
    endcase
  end

  // State-decoded request drops as soon as reset forces state to S_RESET.
  assign mem_addr = pc;
  assign instr_op = opcode;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer

module tb_pc_sequencer;

  logic       clk;
  logic       rst;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic       flags_we;
  logic [3:0] flags_in;
  logic [3:0] cvzn;
  logic [3:0] cccc;
  logic       go;
  logic       instr_valid;
  logic [7:0] instr_op;
  logic       instr_ready;
  logic       branch_taken;

  logic [7:0] mem [256];
  int         checks;
  int         errors;
  int         ack_delay;
  int         wcnt;
  logic       req_prev;
  logic       stray_ack;

  logic [7:0] fetch_log [$];
  logic [7:0] issue_log [$];
  int         taken_cnt;

  localparam int P_START = 0;
  localparam int P_OP    = 1;
  localparam int P_TGT   = 2;
  localparam int P_RES   = 3;
  localparam int P_ISS   = 4;

  int         m_phase;
  logic [7:0] m_addr;
  logic [7:0] m_op;
  logic [7:0] m_tgt;
  logic [3:0] m_flags;
  logic [3:0] m_cccc;

  pc_sequencer #(.RESET_PC(8'h00), .BR_NIBBLE(4'hE)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flags_we(flags_we), .flags_in(flags_in), .cvzn(cvzn), .cccc(cccc), .go(go),
    .instr_valid(instr_valid), .instr_op(instr_op), .instr_ready(instr_ready),
    .branch_taken(branch_taken)
  );

  // branch_logic: {C,V,Z,N}; 0/1 Z, 2/3 C, 4/5 N, 6/7 V, E always, F never
  function automatic logic cond_eval(input logic [3:0] cc, input logic [3:0] f);
    case (cc)
      4'h0: return f[1];
      4'h1: return !f[1];
      4'h2: return f[3];
      4'h3: return !f[3];
      4'h4: return f[0];
      4'h5: return !f[0];
      4'h6: return f[2];
      4'h7: return !f[2];
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign go        = cond_eval(cccc, cvzn);
  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] at_(input logic [7:0] q [$], input int i);
    return (i < q.size()) ? {24'h0, q[i]} : 32'hffff_ffff;
  endfunction

  // Memory responder: each new request is acked after ack_delay wait cycles.
  always @(posedge clk) begin
    #1;
    if (mem_req && req_prev && !mem_ack) wcnt++;
    else wcnt = 0;
    req_prev = mem_req;
    mem_ack  = (mem_req && wcnt >= ack_delay) || stray_ack;
  end

  // Instruction-level model and per-cycle comparison.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_addr", mem_addr, 8'h00);
      chk("rst_instr_valid", instr_valid, 1'b0);
      chk("rst_instr_op", instr_op, 8'h00);
      chk("rst_branch_taken", branch_taken, 1'b0);
      chk("rst_cvzn", cvzn, 4'h0);
      chk("rst_cccc", cccc, 4'h0);
      m_phase = P_START;
      m_addr  = 8'h00;
      m_op    = 8'h00;
      m_flags = 4'h0;
      m_cccc  = 4'h0;
    end else begin
      chk("mem_req", mem_req, (m_phase == P_OP || m_phase == P_TGT));
      if (mem_req) chk("mem_addr", mem_addr, m_addr);
      chk("instr_valid", instr_valid, (m_phase == P_ISS));
      if (m_phase == P_ISS) chk("instr_op", instr_op, m_op);
      chk("branch_taken", branch_taken, (m_phase == P_RES) && cond_eval(m_op[3:0], m_flags));
      chk("cvzn", cvzn, m_flags);
      chk("cccc", cccc, m_cccc);

      if (mem_req && mem_ack) fetch_log.push_back(mem_addr);
      if (instr_valid && instr_ready) issue_log.push_back(instr_op);
      if (branch_taken) taken_cnt++;

      case (m_phase)
        P_START: m_phase = P_OP;
        P_OP: if (mem_req && mem_ack) begin
          m_op    = mem[m_addr];
          m_addr  = m_addr + 8'd1;
          m_phase = (m_op[7:4] == 4'hE) ? P_TGT : P_ISS;
        end
        P_TGT: if (mem_req && mem_ack) begin
          m_tgt   = mem[m_addr];
          m_addr  = m_addr + 8'd1;
          m_cccc  = m_op[3:0];
          m_phase = P_RES;
        end
        P_RES: begin
          if (cond_eval(m_op[3:0], m_flags)) m_addr = m_tgt;
          m_phase = P_OP;
        end
        P_ISS: if (instr_ready) m_phase = P_OP;
        default: m_phase = P_START;
      endcase
      if (flags_we) m_flags = flags_in;
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int i = 0; i < 256; i++) mem[i] = 8'h01;
  endtask

  task automatic clear_logs();
    fetch_log.delete();
    issue_log.delete();
    taken_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic set_flags(input logic [3:0] f);
    flags_we = 1'b1;
    flags_in = f;
    run(1);
    flags_we = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; ack_delay = 0; wcnt = 0; req_prev = 1'b0;
    stray_ack = 1'b0; mem_ack = 1'b0; taken_cnt = 0;
    rst = 1'b1; flags_we = 1'b0; flags_in = 4'h0; instr_ready = 1'b1;
    fill();
    @(posedge clk);
    #1;

    // basic fetch/issue
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34;
    do_reset();
    run(6);
    chk("t1_fetch0", at_(fetch_log, 0), 8'h00);
    chk("t1_issue0", at_(issue_log, 0), 8'h12);
    chk("t1_fetch1", at_(fetch_log, 1), 8'h01);
    chk("t1_issue1", at_(issue_log, 1), 8'h34);

    // branch taken (jump to 0x05 first with unconditional EE)
    fill();
    mem[8'h00] = 8'hEE; mem[8'h01] = 8'h05;
    mem[8'h05] = 8'hE0; mem[8'h06] = 8'h40; mem[8'h40] = 8'h55;
    do_reset();
    set_flags(4'b0010);
    run(11);
    chk("t2_fetch_tgt", at_(fetch_log, 4), 8'h40);
    chk("t2_taken", taken_cnt, 2);
    chk("t2_first_issue", at_(issue_log, 0), 8'h55);
    chk("t2_cccc_hold", cccc, 4'h0);

    // branch not taken
    mem[8'h05] = 8'hE1; mem[8'h07] = 8'h66;
    do_reset();
    set_flags(4'b0010);
    run(11);
    chk("t3_fetch_next", at_(fetch_log, 4), 8'h07);
    chk("t3_taken", taken_cnt, 1);
    chk("t3_first_issue", at_(issue_log, 0), 8'h66);
    chk("t3_cccc_hold", cccc, 4'h1);

    // wait states and backpressure
    fill();
    mem[8'h00] = 8'h12;
    ack_delay = 3;
    instr_ready = 1'b0;
    do_reset();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (instr_valid) begin seen = 1'b1; break; end
        run(1);
      end
      chk("t4_valid_seen", seen, 1'b1);
    end
    run(3);
    chk("t4_no_transfer_yet", issue_log.size(), 0);
    instr_ready = 1'b1;
    run(1);
    chk("t4_one_transfer", issue_log.size(), 1);
    run(2);
    chk("t4_still_one", issue_log.size(), 1);
    chk("t4_issue_op", at_(issue_log, 0), 8'h12);
    ack_delay = 0;

    // wrap-around: non-branch at 0xFF
    fill();
    mem[8'h00] = 8'hEE; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h21;
    do_reset();
    run(8);
    chk("t5a_fetch_ff", at_(fetch_log, 2), 8'hFF);
    chk("t5a_wrap", at_(fetch_log, 3), 8'h00);

    // wrap-around: not-taken branch at 0xFE
    fill();
    mem[8'h00] = 8'hEE; mem[8'h01] = 8'hFE; mem[8'hFE] = 8'hEF; mem[8'hFF] = 8'h99;
    do_reset();
    run(9);
    chk("t5b_tgt_ff", at_(fetch_log, 3), 8'hFF);
    chk("t5b_wrap", at_(fetch_log, 4), 8'h00);
    chk("t5b_taken", taken_cnt, 1);

    // flags_we in the RESOLVE cycle
    fill();
    mem[8'h00] = 8'hE0; mem[8'h01] = 8'h30; mem[8'h30] = 8'h77;
    do_reset();
    set_flags(4'b0010);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (fetch_log.size() >= 2) begin seen = 1'b1; break; end
        run(1);
      end
      chk("t6_tgt_fetched", seen, 1'b1);
    end
    flags_we = 1'b1;
    flags_in = 4'b0000;
    run(1);
    flags_we = 1'b0;
    chk("t6_cvzn_new", cvzn, 4'h0);
    run(3);
    chk("t6_fetch_tgt", at_(fetch_log, 2), 8'h30);
    chk("t6_taken", taken_cnt, 1);

    // reset during FETCH_TGT, late ack ignored
    fill();
    mem[8'h00] = 8'hE0;
    ack_delay = 3;
    do_reset();
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        if (fetch_log.size() >= 1) begin seen = 1'b1; break; end
        run(1);
      end
      chk("t7_op_fetched", seen, 1'b1);
    end
    chk("t7_req_before", mem_req, 1'b1);
    chk("t7_addr_before", mem_addr, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_req_drop", mem_req, 1'b0);
    chk("t7_addr_reset", mem_addr, 8'h00);
    @(posedge clk);
    #1;
    stray_ack = 1'b1;
    run(1);
    rst = 1'b0;
    clear_logs();
    run(1);
    stray_ack = 1'b0;
    ack_delay = 0;
    run(4);
    chk("t7_restart", at_(fetch_log, 0), 8'h00);
    chk("t7_restart_tgt", at_(fetch_log, 1), 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
